vga_config_sequencer: RTL and testbench

Frame-synchronous configuration controller for the `vga` system's `face_select`, `kernel_select` and `intensity` inputs. It accepts requests from two requesters, a user port with valid/ready handshake and an internal demo cycler, with fixed priority to the user port. It holds each accepted request in a shadow register and applies it only at a frame boundary, on the falling edge of `vga_VS`. This prevents tearing or mixed-kernel frames. It sits between the board I/O logic and the `vga` system instance.

---
 rtl/vga_cfg_pkg.sv | 39 +++
 rtl/vga_frame_tick.sv | 35 +++
 rtl/vga_config_sequencer.sv | 108 ++++++++++
 tb/tb_vga_config_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_cfg_pkg.sv
// Shared widths, reset defaults, state encoding and kernel helpers for the
// vga configuration sequencer.
package vga_cfg_pkg;

   localparam int unsigned FACE_W   = 2;
   localparam int unsigned KERNEL_W = 3;
   localparam int unsigned INT_W    = 8;

   localparam logic [FACE_W-1:0]   FACE_RST   = '0;
   localparam logic [KERNEL_W-1:0] KERNEL_RST = '0;
   localparam logic [INT_W-1:0]    INT_RST    = 8'd128;

   typedef enum logic [1:0] {
      StIdle,
      StPending,
      StApply
   } state_e;

   typedef struct packed {
      logic [FACE_W-1:0]   face;
      logic [KERNEL_W-1:0] kernel;
      logic [INT_W-1:0]    intensity;
   } cfg_t;

   localparam cfg_t CFG_RST = '{face: FACE_RST, kernel: KERNEL_RST, intensity: INT_RST};

   function automatic logic [KERNEL_W-1:0] clamp_kernel(input logic [KERNEL_W-1:0] k,
                                                        input int unsigned num);
      if (32'(k) >= num) return KERNEL_W'(num - 1);
      return k;
   endfunction

   function automatic logic [KERNEL_W-1:0] next_kernel(input logic [KERNEL_W-1:0] k,
                                                       input int unsigned num);
      if (32'(k) == num - 1) return '0;
      return k + KERNEL_W'(1);
   endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// Synchronises the active-low vga_VS and emits a one-cycle pulse per frame,
// three clocks after the first low sample that follows a high sample.
module vga_frame_tick (
   input  logic clk_clk,
   input  logic reset_reset_n,
   input  logic vga_VS,
   output logic frame_tick
);

   logic r_sync1;
   logic r_sync2;
   logic r_vs_prev;
   logic r_fall;
   logic r_tick;

   // Sync stages reset high so a released reset never looks like a falling edge.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_vs_prev <= 1'b1;
         r_fall    <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         r_sync1   <= vga_VS;
         r_sync2   <= r_sync1;
         r_vs_prev <= r_sync2;
         r_fall    <= r_vs_prev & ~r_sync2;
         r_tick    <= r_fall;
      end
   end

   assign frame_tick = r_tick;

endmodule

// File: rtl/vga_config_sequencer.sv
// Frame-synchronous configuration controller: accepts user or demo requests into
// a shadow register and applies it to the vga select outputs at a frame boundary.
module vga_config_sequencer
   import vga_cfg_pkg::*;
#(
   parameter int unsigned NUM_KERNELS        = 5,
   parameter int unsigned DEMO_PERIOD_FRAMES = 120
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic                vga_VS,
   input  logic                user_req_valid,
   output logic                user_req_ready,
   input  logic [FACE_W-1:0]   user_req_face,
   input  logic [KERNEL_W-1:0] user_req_kernel,
   input  logic [INT_W-1:0]    user_req_intensity,
   input  logic                demo_en,
   output logic [FACE_W-1:0]   face_select,
   output logic [KERNEL_W-1:0] kernel_select,
   output logic [INT_W-1:0]    intensity,
   output logic                cfg_update,
   output logic                pending
);

   localparam int unsigned CNT_W = (DEMO_PERIOD_FRAMES > 1) ? $clog2(DEMO_PERIOD_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEMO_PERIOD_FRAMES - 1);

   state_e           r_state;
   state_e           w_state_nxt;
   cfg_t             r_shadow;
   cfg_t             w_shadow_nxt;
   cfg_t             r_cfg;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_cfg_update;
   logic             r_ready;
   logic             w_frame_tick;
   logic             w_hs;
   logic             w_demo_due;

   vga_frame_tick u_frame_tick (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .vga_VS        (vga_VS),
      .frame_tick    (w_frame_tick)
   );

   assign w_hs       = user_req_valid & r_ready & (r_state == StIdle);
   assign w_demo_due = (r_state == StIdle) & demo_en & w_frame_tick & (r_cnt == CNT_LAST);

   always_comb begin
      w_state_nxt  = r_state;
      w_shadow_nxt = r_shadow;
      w_cnt_nxt    = r_cnt;

      unique case (r_state)
         StIdle: begin
            // User request outranks a demo step landing in the same cycle.
            if (w_hs) begin
               w_shadow_nxt = '{face:      user_req_face,
                                kernel:    clamp_kernel(user_req_kernel, NUM_KERNELS),
                                intensity: user_req_intensity};
               w_state_nxt  = StPending;
            end else if (w_demo_due) begin
               w_shadow_nxt = '{face:      r_cfg.face,
                                kernel:    next_kernel(r_cfg.kernel, NUM_KERNELS),
                                intensity: r_cfg.intensity};
               w_state_nxt  = StPending;
            end
         end
         StPending: if (w_frame_tick) w_state_nxt = StApply;
         StApply:   w_state_nxt = StIdle;
         default:   w_state_nxt = StIdle;
      endcase

      if (w_hs || !demo_en) begin
         w_cnt_nxt = '0;
      end else if ((r_state == StIdle) && w_frame_tick) begin
         w_cnt_nxt = (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_state      <= StIdle;
         r_shadow     <= CFG_RST;
         r_cfg        <= CFG_RST;
         r_cnt        <= '0;
         r_cfg_update <= 1'b0;
         r_ready      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_shadow     <= w_shadow_nxt;
         r_cnt        <= w_cnt_nxt;
         r_cfg_update <= (r_state == StApply);
         r_ready      <= (w_state_nxt == StIdle);
         if (r_state == StApply) r_cfg <= r_shadow;
      end
   end

   assign face_select    = r_cfg.face;
   assign kernel_select  = r_cfg.kernel;
   assign intensity      = r_cfg.intensity;
   assign cfg_update     = r_cfg_update;
   assign user_req_ready = r_ready;
   assign pending        = (r_state == StPending);

endmodule

// File: tb/tb_vga_config_sequencer.sv
// Randomised bench for vga_config_sequencer against a frame-level reference model,
// with directed phases for deferred apply, clamping, demo cycling, collision and reset.
module tb_vga_config_sequencer;

   localparam int unsigned NK  = 5;
   localparam int unsigned PER = 2;
   localparam int LIM = 800;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       vs;
   logic       valid;
   logic       demo_en;
   logic [1:0] u_face;
   logic [2:0] u_kernel;
   logic [7:0] u_int;
   logic       ready;
   logic       upd;
   logic       pend;
   logic [1:0] face;
   logic [2:0] kernel;
   logic [7:0] intensity;

   always #5 clk = ~clk;

   vga_config_sequencer #(
      .NUM_KERNELS        (NK),
      .DEMO_PERIOD_FRAMES (PER)
   ) dut (
      .clk_clk            (clk),
      .reset_reset_n      (rst_n),
      .vga_VS             (vs),
      .user_req_valid     (valid),
      .user_req_ready     (ready),
      .user_req_face      (u_face),
      .user_req_kernel    (u_kernel),
      .user_req_intensity (u_int),
      .demo_en            (demo_en),
      .face_select        (face),
      .kernel_select      (kernel),
      .intensity          (intensity),
      .cfg_update         (upd),
      .pending            (pend)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: VS sample history, frame ticks, and a request that is
   // captured, armed by a tick, and shown on the outputs one edge later.
   bit h[5]   = '{1, 1, 1, 1, 1};
   bit rh[4]  = '{1, 1, 1, 1};
   bit m_tick = 0;
   bit m_upd, m_ready, m_busy, m_armed;
   int m_face, m_kernel, m_int, s_face, s_kernel, s_int, m_cnt;
   int fpos = 10;
   int flen = 30;

   task automatic model_edge();
      bit t, hs, was_busy;
      for (int i = 4; i > 0; i--) h[i] = h[i-1];
      h[0] = (!rst_n) ? 1'b1 : vs;
      for (int i = 3; i > 0; i--) rh[i] = rh[i-1];
      rh[0] = !rst_n;
      t = m_tick;
      m_tick = !(rh[0] | rh[1] | rh[2] | rh[3]) && h[4] && !h[3];
      if (!rst_n) begin
         m_face = 0; m_kernel = 0; m_int = 128;
         s_face = 0; s_kernel = 0; s_int = 128;
         m_upd = 0; m_ready = 0; m_busy = 0; m_armed = 0; m_cnt = 0;
      end else begin
         was_busy = m_busy;
         hs = !m_busy && valid && m_ready;
         m_upd = 0;
         if (m_busy) begin
            if (m_armed) begin
               m_face = s_face; m_kernel = s_kernel; m_int = s_int;
               m_upd = 1; m_busy = 0; m_armed = 0;
            end else if (t) begin
               m_armed = 1;
            end
         end else if (hs) begin
            s_face = int'(u_face);
            s_kernel = (int'(u_kernel) >= NK) ? NK - 1 : int'(u_kernel);
            s_int = int'(u_int);
            m_busy = 1;
         end else if (demo_en && t && m_cnt == PER - 1) begin
            s_face = m_face; s_int = m_int;
            s_kernel = (m_kernel + 1) % NK;
            m_busy = 1;
         end
         if (hs || !demo_en) m_cnt = 0;
         else if (!was_busy && t) m_cnt = (m_cnt + 1) % PER;
         m_ready = !m_busy;
      end
   endtask

   task automatic compare();
      check_val("face", 32'(face), 32'(m_face));
      check_val("kernel", 32'(kernel), 32'(m_kernel));
      check_val("intensity", 32'(intensity), 32'(m_int));
      check_val("cfg_update", 32'(upd), 32'(m_upd));
      check_val("pending", 32'(pend), 32'(m_busy && !m_armed));
      check_val("ready", 32'(ready), 32'(m_ready));
      check_val("frame_tick", 32'(dut.u_frame_tick.frame_tick), 32'(m_tick));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
      fpos++;
      if (fpos >= flen) begin
         fpos = 0;
         flen = 20 + $urandom_range(0, 15);
      end
      vs = (fpos < 3) ? 1'b0 : 1'b1;
   endtask

   task automatic wait_tick();
      int n = 0;
      while (!m_tick && n < LIM) begin step(); n++; end
      check_val("tick_wait", 32'(n < LIM), 1);
   endtask

   task automatic wait_upd();
      int n = 0;
      while (!m_upd && n < LIM) begin step(); n++; end
      check_val("upd_wait", 32'(n < LIM), 1);
   endtask

   task automatic wait_pending(output int ticks);
      int n = 0;
      ticks = 0;
      while (!(m_busy && !m_armed) && n < LIM) begin
         if (m_tick) ticks++;
         step();
         n++;
      end
      check_val("pending_wait", 32'(n < LIM), 1);
   endtask

   task automatic send(input int f, input int k, input int i);
      int n = 0;
      while (!m_ready && n < LIM) begin step(); n++; end
      check_val("ready_wait", 32'(n < LIM), 1);
      valid = 1'b1; u_face = 2'(f); u_kernel = 3'(k); u_int = 8'(i);
      step();
      valid = 1'b0;
   endtask

   initial begin
      int t, cnt;
      rst_n = 1'b0; vs = 1'b1; valid = 1'b0; demo_en = 1'b0;
      u_face = '0; u_kernel = '0; u_int = '0;

      // Reset and idle
      repeat (4) step();
      check_val("rst_ready", 32'(ready), 0);
      rst_n = 1'b1;
      step();
      check_val("rel_ready", 32'(ready), 1);
      check_val("rel_int", 32'(intensity), 128);
      cnt = 0;
      for (int i = 0; i < 110; i++) begin step(); if (upd) cnt++; end
      check_val("idle_no_update", 32'(cnt), 0);

      // Deferred apply
      wait_tick();
      repeat (10) step();
      send(2, 3, 200);
      wait_tick();
      check_val("defer_hold_int", 32'(intensity), 128);
      wait_upd();
      check_val("defer_face", 32'(face), 2);
      check_val("defer_kernel", 32'(kernel), 3);
      check_val("defer_int", 32'(intensity), 200);
      step();
      check_val("defer_single_pulse", 32'(upd), 0);

      // Kernel clamp
      send(0, 7, 10);
      wait_upd();
      check_val("clamp_kernel", 32'(kernel), 4);

      // Demo cycling from kernel 4
      send(1, 4, 50);
      wait_upd();
      demo_en = 1'b1;
      wait_pending(t);
      check_val("demo_gap1", 32'(t), 2);
      wait_upd();
      check_val("demo_k0", 32'(kernel), 0);
      check_val("demo_face", 32'(face), 1);
      check_val("demo_int", 32'(intensity), 50);
      wait_pending(t);
      check_val("demo_gap2", 32'(t), 2);
      wait_upd();
      check_val("demo_k1", 32'(kernel), 1);

      // Collision: handshake on the edge where the demo step is due
      cnt = 0;
      while (!(m_ready && !m_busy && m_cnt == PER - 1 && m_tick) && cnt < LIM) begin
         step(); cnt++;
      end
      check_val("coll_wait", 32'(cnt < LIM), 1);
      valid = 1'b1; u_face = 2'd3; u_kernel = 3'd2; u_int = 8'd77;
      step();
      valid = 1'b0;
      check_val("coll_pending", 32'(pend), 1);
      wait_upd();
      check_val("coll_face", 32'(face), 3);
      check_val("coll_kernel", 32'(kernel), 2);
      check_val("coll_int", 32'(intensity), 77);
      wait_pending(t);
      check_val("coll_gap", 32'(t), 2);
      wait_upd();
      check_val("coll_next_kernel", 32'(kernel), 3);

      // Reset while pending
      demo_en = 1'b0;
      wait_tick();
      repeat (2) step();
      send(2, 1, 9);
      check_val("rp_pending", 32'(pend), 1);
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      check_val("rp_pend_clr", 32'(pend), 0);
      check_val("rp_kernel", 32'(kernel), 0);
      check_val("rp_int", 32'(intensity), 128);
      cnt = 0;
      for (int i = 0; i < 110; i++) begin step(); if (upd) cnt++; end
      check_val("rp_no_update", 32'(cnt), 0);

      // Random traffic
      demo_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         valid    = ($urandom_range(0, 2) == 0);
         u_face   = 2'($urandom);
         u_kernel = 3'($urandom);
         u_int    = 8'($urandom);
         if ($urandom_range(0, 99) == 0) demo_en = ~demo_en;
         rst_n = ($urandom_range(0, 399) != 0);
         step();
      end
      rst_n = 1'b1;
      valid = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
